spi_ads_axil_slave: RTL and testbench
=====================================

Name: spi_ads_axil_slave

Overview:
AXI4-Lite responder for the SPI ADS master IP. It is the slave end of the S00_AXI port that the VIP master drives. The block holds the control/config registers that drive the SPI ADS core, and exposes status plus a sample FIFO that the core fills with ADC words. The FIFO is popped by AXI reads of the DATA register.

Parameters:
C_S_AXI_DATA_WIDTH, 32, AXI data width (only 32 supported)
C_S_AXI_ADDR_WIDTH, 4, byte address width; 4 registers decoded on addr[3:2]
FIFO_DEPTH, 16, sample FIFO entries (power of two, >=2)

Ports:
s00_axi_aclk  in  1  clock
s00_axi_areset  in  1  synchronous active-high reset
s00_axi_awaddr  in  4  write address
s00_axi_awprot  in  3  ignored
s00_axi_awvalid  in  1  write address valid
s00_axi_awready  out  1  write address ready
s00_axi_wdata  in  32  write data
s00_axi_wstrb  in  4  byte strobes
s00_axi_wvalid  in  1  write data valid
s00_axi_wready  out  1  write data ready
s00_axi_bresp  out  2  always 2'b00
s00_axi_bvalid  out  1  write response valid
s00_axi_bready  in  1  write response ready
s00_axi_araddr  in  4  read address
s00_axi_arprot  in  3  ignored
s00_axi_arvalid  in  1  read address valid
s00_axi_arready  out  1  read address ready
s00_axi_rdata  out  32  read data
s00_axi_rresp  out  2  always 2'b00
s00_axi_rvalid  out  1  read data valid
s00_axi_rready  in  1  read data ready
ctrl  out  32  CTRL register contents to SPI core
clkdiv  out  32  CLKDIV register contents to SPI core
sample_valid  in  1  core presents a sample this cycle
sample_data  in  32  ADC sample word

Behaviour:
- Reset: all outputs 0 (awready, wready, arready, bvalid, rvalid, rdata, ctrl, clkdiv). FIFO empty; overflow flag cleared.
- Register map:
  - 0x0 CTRL: RW.
  - 0x4 CLKDIV: RW.
  - 0x8 STATUS: RO except bit 16.
    - [15:0] FIFO level.
    - [16] overflow sticky, write-1-to-clear.
    - [17] fifo empty.
    - [18] fifo full.
  - 0xC DATA: RO, pops FIFO.
  - Writes to RO fields are ignored; the write is still acknowledged with OKAY.
- Write channel: AW and W are accepted independently, in either order or in the same cycle.
  - awready = 1 while no address is latched and bvalid = 0. wready is the same rule applied to data.
  - Once both address and data are latched, the register update happens on the next cycle, with wstrb honoured per byte. bvalid rises in that same cycle.
  - AW and W in the same cycle: bvalid is asserted 2 cycles after the handshake.
  - bvalid holds until bready; the latches clear on the B handshake. Only one write is outstanding at a time.
- Read channel: arready = 1 while rvalid = 0 and no read is pending.
  - On the AR handshake, rdata and rvalid = 1 are registered next cycle. rdata is held stable until the rready handshake.
  - A DATA read pops the FIFO at the AR handshake if it is not empty, and rdata = head.
  - A DATA read on an empty FIFO returns 0 and causes no pop.
- Read and write in the same cycle are both served; the channels are independent.
  - A STATUS read returns the value present at the AR handshake cycle.
- FIFO behaviour:
  - A push (sample_valid) and a pop in the same cycle are both performed, including when the FIFO is full; level is unchanged.
  - A push while full with no pop: the sample is dropped and overflow is set.
  - Overflow set and W1C in the same cycle: set wins.
  - Pointers wrap modulo FIFO_DEPTH. Level saturates at FIFO_DEPTH.
- Reset asserted mid-transaction aborts it: bvalid/rvalid drop and the latches and FIFO clear. The master must reissue the transaction.

Test Plan:
- Write 0x1,0x2 to 0x0,0x4 then read back -> rdata 0x1,0x2; ctrl=1 and clkdiv=2 on the cycle bvalid rises; bresp/rresp 0.
- W presented 3 cycles before AW; wstrb=4'b0010, wdata=0xAABBCCDD to CTRL=0x11223344 -> bvalid only after AW; ctrl=0x1122CC44.
- Push 3 samples 0xA0,0xA1,0xA2; read STATUS -> 0x00000003; three DATA reads -> 0xA0,0xA1,0xA2; fourth DATA read -> 0; STATUS -> 0x00020000.
- Push FIFO_DEPTH+1 samples -> STATUS=0x00050010. Write 0x00010000 to STATUS -> bit16 clears, level stays 16. Repeat the clear coincident with an overflow push -> bit16 stays 1.
- FIFO full, sample_valid coincident with a DATA read handshake -> oldest word returned, new word stored, level stays 16, no overflow.
- rready held low 5 cycles -> rdata/rvalid stable and arready=0. Reset pulsed while bvalid=1 -> bvalid=0 next cycle, ctrl=0.

Source files
------------

// File: rtl/spi_ads_axil_slave.sv
// AXI4-Lite register slave for the SPI ADS core: CTRL/CLKDIV config, STATUS, and a
// sample FIFO filled by the core and popped by DATA reads.
module spi_ads_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 16
) (
  input  logic                            s00_axi_aclk,
  input  logic                            s00_axi_areset,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_awaddr,
  input  logic [2:0]                      s00_axi_awprot,
  input  logic                            s00_axi_awvalid,
  output logic                            s00_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_wdata,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] s00_axi_wstrb,
  input  logic                            s00_axi_wvalid,
  output logic                            s00_axi_wready,
  output logic [1:0]                      s00_axi_bresp,
  output logic                            s00_axi_bvalid,
  input  logic                            s00_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   s00_axi_araddr,
  input  logic [2:0]                      s00_axi_arprot,
  input  logic                            s00_axi_arvalid,
  output logic                            s00_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   s00_axi_rdata,
  output logic [1:0]                      s00_axi_rresp,
  output logic                            s00_axi_rvalid,
  input  logic                            s00_axi_rready,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   ctrl,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   clkdiv,
  input  logic                            sample_valid,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   sample_data
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);

  logic          rdy_q, aw_q, w_q, go_q, bvalid_q, rvalid_q, ovf_q;
  logic [1:0]    awsel_q;
  logic [DW-1:0] wdata_q, rdata_q, ctrl_q, clkdiv_q;
  logic [DW/8-1:0] wstrb_q;
  logic [DW-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0] wptr_q, rptr_q;
  logic [PW:0]   cnt_q;

  logic aw_hs, w_hs, ar_hs, full, empty, pop, push, ovf_set, ovf_clr;
  logic [31:0]   status;
  logic [DW-1:0] rd_val;
  logic          unused_ok;

  assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

  // rdy_q keeps every ready low while reset is held
  assign s00_axi_awready = rdy_q & ~aw_q & ~bvalid_q;
  assign s00_axi_wready  = rdy_q & ~w_q & ~bvalid_q;
  assign s00_axi_arready = rdy_q & ~rvalid_q;
  assign s00_axi_bvalid  = bvalid_q;
  assign s00_axi_rvalid  = rvalid_q;
  assign s00_axi_rdata   = rdata_q;
  assign s00_axi_bresp   = 2'b00;
  assign s00_axi_rresp   = 2'b00;
  assign ctrl            = ctrl_q;
  assign clkdiv          = clkdiv_q;

  assign aw_hs   = s00_axi_awvalid & s00_axi_awready;
  assign w_hs    = s00_axi_wvalid & s00_axi_wready;
  assign ar_hs   = s00_axi_arvalid & s00_axi_arready;
  assign full    = (cnt_q == (PW+1)'(FIFO_DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop     = ar_hs & (s00_axi_araddr[3:2] == 2'd3) & ~empty;
  assign push    = sample_valid & (~full | pop);
  assign ovf_set = sample_valid & full & ~pop;
  assign ovf_clr = go_q & (awsel_q == 2'd2) & wstrb_q[2] & wdata_q[16];
  assign status  = {13'b0, full, empty, ovf_q, 16'(cnt_q)};

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] d,
                                          input logic [DW/8-1:0] s);
    merge = old;
    for (int i = 0; i < DW/8; i++)
      if (s[i]) merge[i*8 +: 8] = d[i*8 +: 8];
  endfunction

  always_comb begin
    rd_val = '0;
    case (s00_axi_araddr[3:2])
      2'd0:    rd_val = ctrl_q;
      2'd1:    rd_val = clkdiv_q;
      2'd2:    rd_val = DW'(status);
      default: rd_val = empty ? '0 : mem_q[rptr_q];
    endcase
  end

  always_ff @(posedge s00_axi_aclk) begin
    if (s00_axi_areset) begin
      rdy_q    <= 1'b0;
      aw_q     <= 1'b0;
      w_q      <= 1'b0;
      go_q     <= 1'b0;
      bvalid_q <= 1'b0;
      rvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
      awsel_q  <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      rdata_q  <= '0;
      ctrl_q   <= '0;
      clkdiv_q <= '0;
      wptr_q   <= '0;
      rptr_q   <= '0;
      cnt_q    <= '0;
    end else begin
      rdy_q <= 1'b1;
      if (aw_hs) begin
        aw_q    <= 1'b1;
        awsel_q <= s00_axi_awaddr[3:2];
      end
      if (w_hs) begin
        w_q     <= 1'b1;
        wdata_q <= s00_axi_wdata;
        wstrb_q <= s00_axi_wstrb;
      end
      // one-cycle gap between both-latched and the commit, so go_q fires once per write
      go_q <= aw_q & w_q & ~go_q & ~bvalid_q;
      if (go_q) begin
        bvalid_q <= 1'b1;
        if (awsel_q == 2'd0) ctrl_q   <= merge(ctrl_q, wdata_q, wstrb_q);
        if (awsel_q == 2'd1) clkdiv_q <= merge(clkdiv_q, wdata_q, wstrb_q);
      end
      if (bvalid_q & s00_axi_bready) begin
        bvalid_q <= 1'b0;
        aw_q     <= 1'b0;
        w_q      <= 1'b0;
      end
      if (ar_hs) begin
        rvalid_q <= 1'b1;
        rdata_q  <= rd_val;
      end else if (rvalid_q & s00_axi_rready) begin
        rvalid_q <= 1'b0;
      end
      if (ovf_set)      ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
      cnt_q <= cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    end
  end

  // storage needs no reset; the pointers define what is valid
  always_ff @(posedge s00_axi_aclk) begin
    if (!s00_axi_areset && push) mem_q[wptr_q] <= sample_data;
  end
endmodule

// File: tb/tb_spi_ads_axil_slave.sv
// Randomized self-checking bench for spi_ads_axil_slave against a queue-based register/FIFO model.
module tb_spi_ads_axil_slave;
  localparam int D = 16;
  logic clk = 0, areset = 0;
  logic [3:0] awaddr = 0, araddr = 0;
  logic [2:0] awprot = 0, arprot = 0;
  logic awvalid = 0, wvalid = 0, bready = 0, arvalid = 0, rready = 0, sample_valid = 0;
  logic [31:0] wdata = 0, sample_data = 0;
  logic [3:0] wstrb = 0;
  logic awready, wready, bvalid, arready, rvalid;
  logic [1:0] bresp, rresp;
  logic [31:0] rdata, ctrl, clkdiv;

  int total = 0, bad = 0;
  logic [31:0] m_ctrl, m_clkdiv, mq[$];
  bit m_ovf;

  spi_ads_axil_slave #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .FIFO_DEPTH(D)) dut (
    .s00_axi_aclk(clk), .s00_axi_areset(areset),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .ctrl(ctrl), .clkdiv(clkdiv), .sample_valid(sample_valid), .sample_data(sample_data));

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic logic [31:0] bmerge(input logic [31:0] o, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r = o;
    for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_status();
    int n = mq.size();
    return (n == D ? 32'h40000 : 0) | (n == 0 ? 32'h20000 : 0) | (m_ovf ? 32'h10000 : 0) | n;
  endfunction

  function automatic void m_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    case (a[3:2])
      2'd0: m_ctrl = bmerge(m_ctrl, d, s);
      2'd1: m_clkdiv = bmerge(m_clkdiv, d, s);
      2'd2: if (s[2] && d[16]) m_ovf = 0;
      default: ;
    endcase
  endfunction

  function automatic logic [31:0] m_read(input logic [3:0] a);
    case (a[3:2])
      2'd0: return m_ctrl;
      2'd1: return m_clkdiv;
      2'd2: return m_status();
      default: return (mq.size() == 0) ? 32'h0 : mq.pop_front();
    endcase
  endfunction

  function automatic void m_push(input logic [31:0] d);
    if (mq.size() < D) mq.push_back(d); else m_ovf = 1;
  endfunction

  function automatic void m_reset();
    m_ctrl = 0; m_clkdiv = 0; m_ovf = 0; mq.delete();
  endfunction

  // ---------------- bus tasks ----------------
  task automatic do_reset();
    @(negedge clk); areset = 1;
    repeat (2) @(posedge clk);
    #1; areset = 0; m_reset();
  endtask

  task automatic do_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                          output int lat, output logic [31:0] c_seen, output logic [31:0] k_seen,
                          output logic [1:0] br);
    bit ad = 0, wd = 0, ah, wh;
    int n = 0;
    lat = -1; c_seen = 'x; k_seen = 'x; br = 'x;
    @(negedge clk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1; wvalid = 1; bready = 1;
    while (!(ad && wd) && n < 50) begin
      ah = awvalid && awready; wh = wvalid && wready;
      @(posedge clk); #1;
      if (ah) begin ad = 1; awvalid = 0; end
      if (wh) begin wd = 1; wvalid = 0; end
      n++;
      if (!(ad && wd)) @(negedge clk);
    end
    awvalid = 0; wvalid = 0;
    if (!(ad && wd)) return;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (bvalid) begin lat = k; c_seen = ctrl; k_seen = clkdiv; br = bresp; break; end
    end
    if (lat > 0) begin @(posedge clk); #1; end
  endtask

  task automatic do_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] rr, output bit ok);
    int n = 0;
    ok = 1; d = 'x; rr = 'x;
    @(negedge clk); araddr = a; arvalid = 1; rready = 1;
    while (!arready && n < 50) begin @(negedge clk); n++; end
    if (n >= 50) begin arvalid = 0; ok = 0; return; end
    @(posedge clk); #1; arvalid = 0;
    @(negedge clk);
    ok = rvalid; d = rdata; rr = rresp;
    @(posedge clk); #1;
  endtask

  task automatic do_push(input logic [31:0] d);
    @(negedge clk); sample_valid = 1; sample_data = d;
    @(posedge clk); #1; sample_valid = 0;
    m_push(d);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk); areset = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if ({awready, wready, arready, bvalid, rvalid, bresp, rresp} !== 9'b0 || rdata !== 0 || ctrl !== 0 || clkdiv !== 0) begin
      bad++;
      $display("FAIL reset_outputs: got aw%b w%b ar%b b%b r%b rdata=%h ctrl=%h clkdiv=%h, want all 0",
               awready, wready, arready, bvalid, rvalid, rdata, ctrl, clkdiv);
    end
    @(posedge clk); #1; areset = 0; m_reset();
  endtask

  task automatic test_regs();
    int lat; logic [31:0] c, k, d; logic [1:0] br, rr; bit ok;
    do_write(4'h0, 32'h1, 4'hF, lat, c, k, br); m_write(4'h0, 32'h1, 4'hF);
    total++;
    if (lat !== 2 || c !== 32'h1 || br !== 2'b00) begin
      bad++; $display("FAIL ctrl_write: lat=%0d ctrl=%h bresp=%b, want lat=2 ctrl=1 bresp=0", lat, c, br);
    end
    do_write(4'h4, 32'h2, 4'hF, lat, c, k, br); m_write(4'h4, 32'h2, 4'hF);
    total++;
    if (lat !== 2 || k !== 32'h2 || c !== 32'h1) begin
      bad++; $display("FAIL clkdiv_write: lat=%0d clkdiv=%h ctrl=%h, want 2/2/1", lat, k, c);
    end
    do_read(4'h0, d, rr, ok);
    total++;
    if (!ok || d !== 32'h1 || rr !== 2'b00) begin
      bad++; $display("FAIL ctrl_read: got %h rresp=%b ok=%0d, want 00000001 rresp=0", d, rr, ok);
    end
    do_read(4'h4, d, rr, ok);
    total++;
    if (!ok || d !== 32'h2) begin
      bad++; $display("FAIL clkdiv_read: got %h ok=%0d, want 00000002", d, ok);
    end
  endtask

  task automatic test_w_before_aw();
    int lat, n; logic [31:0] c, k; logic [1:0] br; bit early;
    do_write(4'h0, 32'h11223344, 4'hF, lat, c, k, br); m_write(4'h0, 32'h11223344, 4'hF);
    @(negedge clk); wdata = 32'hAABBCCDD; wstrb = 4'b0010; wvalid = 1; bready = 1;
    n = 0;
    while (!wready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1; wvalid = 0;
    early = 0;
    for (int i = 0; i < 3; i++) begin @(negedge clk); if (bvalid) early = 1; end
    awaddr = 4'h0; awvalid = 1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1; awvalid = 0;
    lat = -1;
    for (int j = 1; j <= 10; j++) begin @(posedge clk); #1; if (bvalid) begin lat = j; break; end end
    m_write(4'h0, 32'hAABBCCDD, 4'b0010);
    total++;
    if (early || lat < 0 || ctrl !== m_ctrl || m_ctrl !== 32'h1122CC44) begin
      bad++; $display("FAIL w_before_aw: early_b=%0d lat=%0d ctrl=%h, want no early b, ctrl=1122cc44", early, lat, ctrl);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fifo_basic();
    logic [31:0] d, e; logic [1:0] rr; bit ok;
    do_reset();
    do_push(32'hA0); do_push(32'hA1); do_push(32'hA2);
    e = m_read(4'h8); do_read(4'h8, d, rr, ok);
    total++;
    if (!ok || d !== e || e !== 32'h3) begin bad++; $display("FAIL status_level3: got %h want %h", d, e); end
    for (int i = 0; i < 4; i++) begin
      e = m_read(4'hC); do_read(4'hC, d, rr, ok);
      total++;
      if (!ok || d !== e) begin bad++; $display("FAIL data_read%0d: got %h want %h", i, d, e); end
    end
    e = m_read(4'h8); do_read(4'h8, d, rr, ok);
    total++;
    if (!ok || d !== e || e !== 32'h20000) begin bad++; $display("FAIL status_empty: got %h want %h", d, e); end
  endtask

  task automatic test_overflow();
    int lat; logic [31:0] c, k, d, e; logic [1:0] br, rr; bit ok;
    do_reset();
    for (int i = 0; i <= D; i++) do_push($urandom);
    e = m_read(4'h8); do_read(4'h8, d, rr, ok);
    total++;
    if (!ok || d !== e || e !== 32'h50010) begin bad++; $display("FAIL status_ovf: got %h want %h", d, e); end
    do_write(4'h8, 32'h10000, 4'hF, lat, c, k, br); m_write(4'h8, 32'h10000, 4'hF);
    e = m_read(4'h8); do_read(4'h8, d, rr, ok);
    total++;
    if (!ok || d !== e || e !== 32'h40010) begin bad++; $display("FAIL ovf_w1c: got %h want %h", d, e); end
    // keep pushing into the full FIFO throughout the clear so set and clear coincide
    @(negedge clk); sample_valid = 1; sample_data = 32'hDEAD;
    do_write(4'h8, 32'h10000, 4'hF, lat, c, k, br);
    sample_valid = 0; m_ovf = 1;
    e = m_read(4'h8); do_read(4'h8, d, rr, ok);
    total++;
    if (!ok || d !== e || e !== 32'h50010) begin bad++; $display("FAIL ovf_set_wins: got %h want %h", d, e); end
  endtask

  task automatic test_full_push_pop();
    logic [31:0] d, e, nw; logic [1:0] rr; bit ok, rdy;
    do_reset();
    for (int i = 0; i < D; i++) do_push($urandom);
    nw = $urandom;
    @(negedge clk); araddr = 4'hC; arvalid = 1; rready = 1; sample_valid = 1; sample_data = nw;
    rdy = arready;
    @(posedge clk); #1; arvalid = 0; sample_valid = 0;
    @(negedge clk); d = rdata;
    e = mq.pop_front(); mq.push_back(nw);
    @(posedge clk); #1;
    total++;
    if (!rdy || d !== e) begin bad++; $display("FAIL full_pop_push: arready=%0d got %h want %h", rdy, d, e); end
    e = m_read(4'h8); do_read(4'h8, d, rr, ok);
    total++;
    if (!ok || d !== e || e !== 32'h40010) begin bad++; $display("FAIL full_pop_push_status: got %h want %h", d, e); end
    for (int i = 0; i < D; i++) begin
      e = m_read(4'hC); do_read(4'hC, d, rr, ok);
      total++;
      if (!ok || d !== e) begin bad++; $display("FAIL drain%0d: got %h want %h", i, d, e); end
    end
  endtask

  task automatic test_stall();
    logic [31:0] e, d0; int n; bit stable;
    do_push(32'h5A5A0001);
    e = m_read(4'hC);
    @(negedge clk); araddr = 4'hC; arvalid = 1; rready = 0;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1; arvalid = 0;
    @(negedge clk); d0 = rdata; stable = rvalid && !arready;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!rvalid || rdata !== d0 || arready) stable = 0;
    end
    total++;
    if (!stable || d0 !== e) begin bad++; $display("FAIL rready_stall: stable=%0d rdata=%h want %h", stable, d0, e); end
    rready = 1; @(posedge clk); #1;
    @(negedge clk);
    total++;
    if (rvalid !== 1'b0) begin bad++; $display("FAIL rvalid_clear: got %b want 0", rvalid); end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] c, k, d, e, wv; logic [1:0] br, rr; bit ok;
    wv = $urandom;
    e = m_ctrl;
    fork
      do_write(4'h4, wv, 4'hF, lat, c, k, br);
      do_read(4'h0, d, rr, ok);
    join
    m_write(4'h4, wv, 4'hF);
    total++;
    if (!ok || d !== e || lat !== 2 || clkdiv !== m_clkdiv) begin
      bad++; $display("FAIL concurrent_rw: rd=%h want %h lat=%0d clkdiv=%h want %h", d, e, lat, clkdiv, m_clkdiv);
    end
  endtask

  task automatic test_random();
    int lat, op; logic [31:0] c, k, d, e, v; logic [3:0] a, s; logic [1:0] br, rr; bit ok;
    for (int it = 0; it < 60; it++) begin
      op = $urandom_range(0, 2);
      a = 4'($urandom_range(0, 3) * 4);
      if (op == 0) begin
        v = $urandom; s = 4'($urandom);
        do_write(a, v, s, lat, c, k, br); m_write(a, v, s);
        total++;
        if (lat !== 2 || ctrl !== m_ctrl || clkdiv !== m_clkdiv) begin
          bad++; $display("FAIL rnd_write%0d: lat=%0d ctrl=%h/%h clkdiv=%h/%h", it, lat, ctrl, m_ctrl, clkdiv, m_clkdiv);
        end
      end else if (op == 1) begin
        do_push($urandom);
      end else begin
        e = m_read(a); do_read(a, d, rr, ok);
        total++;
        if (!ok || d !== e) begin bad++; $display("FAIL rnd_read%0d addr=%h: got %h want %h", it, a, d, e); end
      end
    end
  endtask

  task automatic test_reset_mid();
    int n;
    @(negedge clk); awaddr = 4'h0; wdata = 32'h55; wstrb = 4'hF; awvalid = 1; wvalid = 1; bready = 0;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge clk); n++; end
    @(posedge clk); #1; awvalid = 0; wvalid = 0;
    n = 0;
    while (!bvalid && n < 20) begin @(posedge clk); #1; n++; end
    @(negedge clk); areset = 1;
    @(posedge clk); #1;
    total++;
    if (n >= 20 || bvalid !== 1'b0 || ctrl !== 32'h0) begin
      bad++; $display("FAIL reset_mid_write: bvalid_seen=%0d bvalid=%b ctrl=%h, want 0/0", n < 20, bvalid, ctrl);
    end
    @(negedge clk); areset = 0; bready = 1; m_reset();
  endtask

  initial begin
    m_reset();
    test_reset();
    test_regs();
    test_w_before_aw();
    test_fifo_basic();
    test_overflow();
    test_full_push_pop();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_regs();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
